hp_damage_unit: RTL and testbench
=================================

Name: hp_damage_unit

Overview:
- Parametrised hit-point manager for all combatants in the battle machine (player plus N-1 monsters).
- Accepts damage and heal requests over a valid/ready handshake.
- Applies saturating arithmetic, invulnerability frames and sticky death flags.
- Reports completion with a done pulse that replaces the ad-hoc damage-complete strobe.

Parameters:
- NUM_CH, 2, number of combatant channels (channel 0 = player); 1..8.
- HP_W, 8, width of one HP value and of request amounts.
- MAX_HP, 100, reset and restart HP for every channel; must be < 2**HP_W.
- LOW_HP, 20, a channel is "low" when 0 < hp <= LOW_HP.
- IFRAME_CYC, 16, invulnerability cycles after damage is applied; 0 disables i-frames.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- restart  in  1  one-cycle pulse: restore all channels to MAX_HP and clear dead and i-frames.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request this cycle.
- req_ch  in  3  target channel index.
- req_heal  in  1  0 = damage, 1 = heal.
- req_amt  in  HP_W  amount.
- done  out  1  one-cycle pulse: request finished.
- done_ch  out  3  channel of the finished request.
- done_applied  out  HP_W  actual HP change after clamping or blocking.
- done_err  out  1  request rejected (bad channel).
- hp  out  NUM_CH*HP_W  packed HP; channel k occupies [k*HP_W +: HP_W].
- dead  out  NUM_CH  sticky per-channel death flag.
- low  out  NUM_CH  per-channel low-HP flag, combinational from hp.
- invuln  out  NUM_CH  channel's i-frame counter is nonzero.
- all_foes_dead  out  1  dead[NUM_CH-1:1] all set; 0 when NUM_CH = 1.

Behaviour:
- Reset values:
  - every hp = MAX_HP;
  - dead = 0, i-frame counters = 0;
  - done, done_err = 0; done_ch, done_applied = 0;
  - FSM in IDLE, so req_ready = 1 after reset.
- FSM states:
  - IDLE: req_ready = 1. Handshake occurs at edge T when req_valid & req_ready. Capture ch/heal/amt and go to APPLY.
  - APPLY: req_ready = 0. At edge T+1, update hp, dead and the i-frame counter, load the done registers, and go to DONE.
  - DONE: done = 1 for exactly this cycle; req_ready = 0. Next edge returns to IDLE.
  - Throughput: one request per 3 cycles. Latency from acceptance to done high is 2 edges.
- Damage rules:
  - Bad channel (req_ch >= NUM_CH): no state change; done_err = 1, done_applied = 0.
  - Channel dead, or its i-frame counter nonzero: blocked; done_applied = 0, done_err = 0.
  - Otherwise: new = (amt >= hp) ? 0 : hp - amt. done_applied = old - new. Counter loads IFRAME_CYC when done_applied != 0.
  - When new == 0, dead sets in the same edge.
  - A zero-amount damage request completes with applied = 0 and does not start i-frames.
- Heal rules:
  - Dead channel: blocked, applied = 0.
  - Otherwise: new = min(hp + amt, MAX_HP). Compute in HP_W+1 bits so there is no wrap. applied = new - old.
  - Heals ignore i-frames.
- I-frame counters:
  - Each channel decrements by 1 per cycle while nonzero, independent of FSM state.
  - A load in APPLY overrides the decrement for that channel.
  - The counter is wide enough for IFRAME_CYC.
- restart:
  - Highest priority. In any state it forces all hp to MAX_HP and clears dead and counters.
  - FSM goes to IDLE and any in-flight request is dropped with no done pulse.
  - req_ready is 0 in the restart cycle, so no request is accepted on that edge.
- Asynchronous reset mid-operation: immediate return to reset values; in-flight request lost, no done.
- dead is sticky: it clears only on restart or reset.

Decomposition:
- Shared package battle_pkg:
  - FSM state encoding (IDLE/APPLY/DONE);
  - request-kind constants (KIND_DMG = 0, KIND_HEAL = 1);
  - default HP constants (MAX_HP, LOW_HP) reused by the battle machine and display.
- One natural sub-module, hp_channel: holds hp, dead and the i-frame counter for a single channel, and computes clamped damage/heal. It is instantiated NUM_CH times via generate. The top holds the FSM and the done registers.

Test Plan:
- After reset release: hp ch0 = ch1 = 100, dead = 0, req_ready = 1. Damage ch1 amt 10 accepted at T -> done at T+2 with done_applied = 10, hp ch1 = 90, invuln[1] = 1 for 16 cycles.
- Damage ch1 amt 30 while invuln[1] = 1 -> done, applied = 0, hp stays 90. Retry after the counter expires -> hp 60.
- Heal ch0 amt 50 when hp = 80 -> hp 100, applied = 20. Damage ch0 amt 200 -> hp 0, applied = 100, dead[0] = 1. A following heal of 10 -> applied = 0, hp stays 0.
- NUM_CH = 4: kill channels 1-3 -> all_foes_dead rises on the edge where the last one hits 0. req_ch = 5 -> done_err = 1, no state change.
- restart asserted in the APPLY cycle of a damage request -> no done pulse, all hp = 100, dead = 0, req_ready = 1 the next cycle.
- rst_n dropped asynchronously mid-APPLY -> outputs return to reset values before the next clk edge. low[k] = 1 exactly when hp is in 1..20.

Source files
------------

// File: rtl/battle_pkg.sv
// Shared battle-machine definitions: request-handler FSM encoding, request kinds
// and the default HP constants that other blocks also use.
package battle_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StApply,
    StDone
  } hp_state_e;

  localparam logic KIND_DMG  = 1'b0;
  localparam logic KIND_HEAL = 1'b1;

  localparam int unsigned MAX_HP = 100;
  localparam int unsigned LOW_HP = 20;

endpackage

// File: rtl/hp_channel.sv
// One combatant: HP register, sticky death flag and i-frame counter, with the
// clamped damage/heal arithmetic for a request aimed at this channel.
module hp_channel
  import battle_pkg::*;
#(
  parameter int unsigned HP_W       = 8,
  parameter int unsigned MaxHp      = 100,
  parameter int unsigned LowHp      = 20,
  parameter int unsigned IFRAME_CYC = 16,
  parameter int unsigned CNT_W      = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            restart_i,
  input  logic            apply_i,
  input  logic            heal_i,
  input  logic [HP_W-1:0] amt_i,
  output logic [HP_W-1:0] hp_o,
  output logic            dead_o,
  output logic            low_o,
  output logic            invuln_o,
  output logic [HP_W-1:0] applied_o
);

  logic [HP_W-1:0]  hp_q, hp_d;
  logic             dead_q, dead_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [HP_W:0]   heal_sum;
  logic [HP_W-1:0] heal_new, dmg_new, new_hp;
  logic            blocked;

  always_comb begin
    // One extra bit so a large heal cannot wrap before clamping.
    heal_sum = {1'b0, hp_q} + {1'b0, amt_i};
    heal_new = (heal_sum > (HP_W+1)'(MaxHp)) ? HP_W'(MaxHp) : heal_sum[HP_W-1:0];
    dmg_new  = (amt_i >= hp_q) ? '0 : hp_q - amt_i;
    new_hp   = (heal_i == KIND_HEAL) ? heal_new : dmg_new;
    blocked  = dead_q | ((heal_i == KIND_DMG) && (cnt_q != '0));
    if (blocked) begin
      applied_o = '0;
    end else if (heal_i == KIND_HEAL) begin
      applied_o = heal_new - hp_q;
    end else begin
      applied_o = hp_q - dmg_new;
    end
  end

  always_comb begin
    hp_d   = hp_q;
    dead_d = dead_q;
    cnt_d  = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
    if (restart_i) begin
      hp_d   = HP_W'(MaxHp);
      dead_d = 1'b0;
      cnt_d  = '0;
    end else if (apply_i && !blocked) begin
      hp_d = new_hp;
      if (heal_i == KIND_DMG) begin
        if (new_hp == '0) dead_d = 1'b1;
        if (applied_o != '0) cnt_d = CNT_W'(IFRAME_CYC);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hp_q   <= HP_W'(MaxHp);
      dead_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      hp_q   <= hp_d;
      dead_q <= dead_d;
      cnt_q  <= cnt_d;
    end
  end

  assign hp_o     = hp_q;
  assign dead_o   = dead_q;
  assign invuln_o = (cnt_q != '0);
  assign low_o    = (hp_q != '0) && (hp_q <= HP_W'(LowHp));

endmodule

// File: rtl/hp_damage_unit.sv
// Hit-point manager for all combatants: accepts one damage/heal request per three
// cycles, applies it to the addressed hp_channel and reports with a done pulse.
module hp_damage_unit #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned HP_W       = 8,
  parameter int unsigned MAX_HP     = battle_pkg::MAX_HP,
  parameter int unsigned LOW_HP     = battle_pkg::LOW_HP,
  parameter int unsigned IFRAME_CYC = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   restart,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [2:0]             req_ch,
  input  logic                   req_heal,
  input  logic [HP_W-1:0]        req_amt,
  output logic                   done,
  output logic [2:0]             done_ch,
  output logic [HP_W-1:0]        done_applied,
  output logic                   done_err,
  output logic [NUM_CH*HP_W-1:0] hp,
  output logic [NUM_CH-1:0]      dead,
  output logic [NUM_CH-1:0]      low,
  output logic [NUM_CH-1:0]      invuln,
  output logic                   all_foes_dead
);
  import battle_pkg::*;

  localparam int unsigned CntW = (IFRAME_CYC > 0) ? $clog2(IFRAME_CYC + 1) : 1;

  hp_state_e       state_q, state_d;
  logic [2:0]      ch_q;
  logic            heal_q;
  logic [HP_W-1:0] amt_q;
  logic            done_q, done_d;
  logic [2:0]      done_ch_q, done_ch_d;
  logic [HP_W-1:0] done_applied_q, done_applied_d;
  logic            done_err_q, done_err_d;

  logic            accept, bad_ch;
  logic [HP_W-1:0] applied_ch [NUM_CH];
  logic [HP_W-1:0] applied_sel;

  assign req_ready = (state_q == StIdle) && !restart;
  assign accept    = req_valid && req_ready;
  // Widened compare so NUM_CH = 8 does not alias to zero.
  assign bad_ch    = {1'b0, ch_q} >= 4'(NUM_CH);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    hp_channel #(
      .HP_W      (HP_W),
      .MaxHp     (MAX_HP),
      .LowHp     (LOW_HP),
      .IFRAME_CYC(IFRAME_CYC),
      .CNT_W     (CntW)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .restart_i(restart),
      .apply_i  ((state_q == StApply) && (ch_q == 3'(k))),
      .heal_i   (heal_q),
      .amt_i    (amt_q),
      .hp_o     (hp[k*HP_W +: HP_W]),
      .dead_o   (dead[k]),
      .low_o    (low[k]),
      .invuln_o (invuln[k]),
      .applied_o(applied_ch[k])
    );
  end

  if (NUM_CH > 1) begin : g_foes
    assign all_foes_dead = &dead[NUM_CH-1:1];
  end else begin : g_no_foes
    assign all_foes_dead = 1'b0;
  end

  always_comb begin
    applied_sel = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_q == 3'(k)) applied_sel = applied_ch[k];
    end
  end

  always_comb begin
    state_d        = state_q;
    done_d         = 1'b0;
    done_ch_d      = done_ch_q;
    done_applied_d = done_applied_q;
    done_err_d     = done_err_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StApply;
      StApply: begin
        state_d        = StDone;
        done_d         = 1'b1;
        done_ch_d      = ch_q;
        done_err_d     = bad_ch;
        done_applied_d = bad_ch ? '0 : applied_sel;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (restart) begin
      state_d = StIdle;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      ch_q           <= '0;
      heal_q         <= 1'b0;
      amt_q          <= '0;
      done_q         <= 1'b0;
      done_ch_q      <= '0;
      done_applied_q <= '0;
      done_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      done_q         <= done_d;
      done_ch_q      <= done_ch_d;
      done_applied_q <= done_applied_d;
      done_err_q     <= done_err_d;
      if (accept) begin
        ch_q   <= req_ch;
        heal_q <= req_heal;
        amt_q  <= req_amt;
      end
    end
  end

  assign done         = done_q;
  assign done_ch      = done_ch_q;
  assign done_applied = done_applied_q;
  assign done_err     = done_err_q;

endmodule

// File: tb/tb_hp_damage_unit.sv
// Directed bench for hp_damage_unit with four channels: a vector table of requests
// followed by hand-written restart and asynchronous-reset sequences.
module tb_hp_damage_unit;

  localparam int NCH = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           restart = 1'b0;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic [2:0]     req_ch = '0;
  logic           req_heal = 1'b0;
  logic [7:0]     req_amt = '0;
  logic           done;
  logic [2:0]     done_ch;
  logic [7:0]     done_applied;
  logic           done_err;
  logic [NCH*8-1:0] hp;
  logic [NCH-1:0] dead, low, invuln;
  logic           all_foes_dead;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hp_damage_unit #(
    .NUM_CH    (NCH),
    .HP_W      (8),
    .MAX_HP    (100),
    .LOW_HP    (20),
    .IFRAME_CYC(16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .restart      (restart),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_ch       (req_ch),
    .req_heal     (req_heal),
    .req_amt      (req_amt),
    .done         (done),
    .done_ch      (done_ch),
    .done_applied (done_applied),
    .done_err     (done_err),
    .hp           (hp),
    .dead         (dead),
    .low          (low),
    .invuln       (invuln),
    .all_foes_dead(all_foes_dead)
  );

  typedef struct {
    int         gap;
    bit         rst_first;
    logic [2:0] ch;
    logic       heal;
    logic [7:0] amt;
    logic [7:0] e_app;
    logic       e_err;
    int         hch;
    logic [7:0] e_hp;
    logic [3:0] e_dead;
    logic [3:0] e_low;
    logic       e_afd;
    bit         chk_inv;
    logic       e_inv;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input logic [2:0] ch, input logic heal, input logic [7:0] amt);
    int n;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_ch    = ch;
    req_heal  = heal;
    req_amt   = amt;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string s;
    if (v.rst_first) begin
      @(negedge clk) restart = 1'b1;
      @(negedge clk) restart = 1'b0;
    end
    repeat (v.gap) @(posedge clk);
    send(v.ch, v.heal, v.amt);
    $sformat(s, "v%0d", idx);
    chk({s, "_done_early"}, 32'(done), 32'd0);
    @(posedge clk);
    #1;
    chk({s, "_done"}, 32'(done), 32'd1);
    chk({s, "_done_ch"}, 32'(done_ch), 32'(v.ch));
    chk({s, "_applied"}, 32'(done_applied), 32'(v.e_app));
    chk({s, "_err"}, 32'(done_err), 32'(v.e_err));
    chk({s, "_hp"}, 32'(hp[v.hch*8 +: 8]), 32'(v.e_hp));
    chk({s, "_dead"}, 32'(dead), 32'(v.e_dead));
    chk({s, "_low"}, 32'(low), 32'(v.e_low));
    chk({s, "_afd"}, 32'(all_foes_dead), 32'(v.e_afd));
    if (v.chk_inv) chk({s, "_invuln"}, 32'(invuln[v.ch[1:0]]), 32'(v.e_inv));
    @(posedge clk);
    #1 chk({s, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    //          gap rst ch h amt  app err hch hp  dead low afd ci inv
    vecs[0]  = '{0,  0, 1, 0, 10,  10, 0, 1, 90,  0, 0, 0, 1, 1};
    vecs[1]  = '{0,  0, 1, 0, 30,  0,  0, 1, 90,  0, 0, 0, 1, 1};
    vecs[2]  = '{20, 0, 1, 0, 30,  30, 0, 1, 60,  0, 0, 0, 1, 1};
    vecs[3]  = '{0,  0, 0, 0, 20,  20, 0, 0, 80,  0, 0, 0, 1, 1};
    vecs[4]  = '{0,  0, 0, 1, 50,  20, 0, 0, 100, 0, 0, 0, 1, 1};
    vecs[5]  = '{0,  0, 2, 0, 0,   0,  0, 2, 100, 0, 0, 0, 1, 0};
    vecs[6]  = '{20, 0, 0, 0, 200, 100,0, 0, 0,   1, 0, 0, 1, 1};
    vecs[7]  = '{0,  0, 0, 1, 10,  0,  0, 0, 0,   1, 0, 0, 1, 1};
    vecs[8]  = '{0,  0, 5, 0, 10,  0,  1, 1, 60,  1, 0, 0, 0, 0};
    vecs[9]  = '{20, 0, 1, 0, 45,  45, 0, 1, 15,  1, 2, 0, 1, 1};
    vecs[10] = '{0,  0, 2, 0, 255, 100,0, 2, 0,   5, 2, 0, 1, 1};
    vecs[11] = '{0,  0, 3, 0, 100, 100,0, 3, 0,  13, 2, 0, 1, 1};
    vecs[12] = '{20, 0, 1, 0, 15,  15, 0, 1, 0,  15, 0, 1, 1, 1};
    vecs[13] = '{0,  1, 0, 0, 80,  80, 0, 0, 20,  0, 1, 0, 1, 1};
    vecs[14] = '{0,  0, 1, 0, 79,  79, 0, 1, 21,  0, 1, 0, 1, 1};
    vecs[15] = '{20, 0, 0, 0, 1,   1,  0, 0, 19,  0, 1, 0, 1, 1};
    vecs[16] = '{0,  0, 0, 1, 1,   1,  0, 0, 20,  0, 1, 0, 1, 1};
    vecs[17] = '{0,  0, 0, 1, 1,   1,  0, 0, 21,  0, 0, 0, 1, 1};

    repeat (3) @(negedge clk);
    chk("rst_hp", hp, {4{8'd100}});
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_dead", 32'(dead), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_invuln", 32'(invuln), 32'd0);
    chk("rst_low", 32'(low), 32'd0);
    chk("rst_afd", 32'(all_foes_dead), 32'd0);
    chk("rst_done_applied", 32'(done_applied), 32'd0);
    chk("rst_done_err", 32'(done_err), 32'd0);

    for (int i = 0; i < 18; i++) run_vec(vecs[i], i);

    // Restart during APPLY drops the request.
    send(3'd1, 1'b0, 8'd10);
    @(negedge clk) restart = 1'b1;
    #1 chk("rs_ready_low", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("rs_done", 32'(done), 32'd0);
    chk("rs_hp", hp, {4{8'd100}});
    chk("rs_dead", 32'(dead), 32'd0);
    @(negedge clk) restart = 1'b0;
    #1 chk("rs_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 chk("rs_no_done", 32'(done), 32'd0);
    end
    chk("rs_invuln", 32'(invuln), 32'd0);

    // Asynchronous reset during APPLY.
    run_vec('{0, 0, 2, 0, 50, 50, 0, 2, 50, 0, 0, 0, 1, 1}, 100);
    send(3'd3, 1'b0, 8'd20);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("ar_hp", hp, {4{8'd100}});
    chk("ar_invuln", 32'(invuln), 32'd0);
    chk("ar_applied", 32'(done_applied), 32'd0);
    chk("ar_done_ch", 32'(done_ch), 32'd0);
    chk("ar_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("ar_done", 32'(done), 32'd0);
    chk("ar_hp3", 32'(hp[3*8 +: 8]), 32'd100);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 chk("ar_done_after", 32'(done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
